// File: rtl/vga_timing.sv
// Free-running raster timing generator: registered pixel counters plus sync, blank
// and frame-start flags, all decoded from the next-state counters so they stay aligned.
module vga_timing #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblank_out,
    output logic        vblank_out,
    output logic        frame_start_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS_END    = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        hblank_next;
    logic        vblank_next;
    logic        frame_start_next;

    always_comb begin
        h_next = hcount_out + 11'd1;
        v_next = vcount_out;
        if (hcount_out == H_LAST) begin
            h_next = '0;
            v_next = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
    end

    // Flags come from the next-state counters so they land on the same edge as the counts.
    always_comb begin
        hblank_next      = (h_next >= H_VIS_END);
        vblank_next      = (v_next >= V_VIS_END);
        hsync_next       = ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_next       = ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        frame_start_next = (h_next == 11'd0) && (v_next == 11'd0);
    end

    // Reset lands on pixel (0,0) of frame 0 without a frame-start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_out      <= '0;
            vcount_out      <= '0;
            hsync_out       <= ~H_SYNC_POL;
            vsync_out       <= ~V_SYNC_POL;
            hblank_out      <= 1'b0;
            vblank_out      <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            hcount_out      <= h_next;
            vcount_out      <= v_next;
            hsync_out       <= hsync_next;
            vsync_out       <= vsync_next;
            hblank_out      <= hblank_next;
            vblank_out      <= vblank_next;
            frame_start_out <= frame_start_next;
        end
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the display pipeline. It free-runs horizontal and vertical pixel counters and produces registered `hcount`/`vcount`, sync and blanking signals for a 1024x768 frame. Its outputs feed the frame/border generation stage and all downstream drawing stages. All outputs are registered and mutually aligned: every output on a given cycle describes the same pixel.

## Interface
Parameters:
- `H_ACTIVE`, 1024: visible pixels per line
- `H_FP`, 24: horizontal front porch, pixels
- `H_SYNC`, 136: horizontal sync width, pixels
- `H_BP`, 160: horizontal back porch, pixels
- `V_ACTIVE`, 768: visible lines per frame
- `V_FP`, 3: vertical front porch, lines
- `V_SYNC`, 6: vertical sync width, lines
- `V_BP`, 29: vertical back porch, lines
- `H_SYNC_POL`, 0: hsync active level (0 = active-low)
- `V_SYNC_POL`, 0: vsync active level (0 = active-low)

Ports:
- `clk` in 1: pixel clock (65 MHz nominal)
- `rst_n` in 1: already decided; one clock, reset synchronous and active-low
- `hcount_out` out 11: horizontal pixel index, 0..H_TOTAL-1
- `vcount_out` out 11: line index, 0..V_TOTAL-1
- `hsync_out` out 1: horizontal sync, polarity per `H_SYNC_POL`
- `vsync_out` out 1: vertical sync, polarity per `V_SYNC_POL`
- `hblank_out` out 1: 1 when `hcount_out >= H_ACTIVE`
- `vblank_out` out 1: 1 when `vcount_out >= V_ACTIVE`
- `frame_start_out` out 1: single-cycle pulse when outputs show pixel (0,0)

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL likewise (806). Both must be <= 2048; 11-bit counters.
- Horizontal counter increments every cycle and wraps from H_TOTAL-1 to 0.
- Vertical counter increments only on horizontal wrap, and wraps from V_TOTAL-1 to 0 on the cycle where both counters wrap.
- Compute next-state counters combinationally. Decode all flags from the next-state values and register them with the counters, so that flags are never one cycle stale relative to the counts.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), which is [1048,1184) at defaults.
- vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), which is [771,777). vsync is decoded from vcount only, so it changes at the line boundary (hcount=0).
- vblank is asserted for the whole of lines 768..805, including their horizontal active region.
- frame_start_out is 1 exactly when next-state is (0,0) and the frame is not coming out of reset. It pulses once per frame.
- There is no enable input; the block free-runs whenever rst_n is high.

## Timing
- Reset: a posedge with rst_n=0 forces the following values.
  - hcount_out=0, vcount_out=0
  - hblank_out=0, vblank_out=0
  - hsync_out=~H_SYNC_POL, vsync_out=~V_SYNC_POL (inactive)
  - frame_start_out=0
- First posedge with rst_n=1 gives hcount_out=1. The reset state is pixel (0,0) of frame 0; no frame_start pulse is issued for frame 0.
- Reset asserted mid-frame: outputs return to the reset values on the next posedge, regardless of position. No partial-line completion.
- Latency is zero between counters and flags; all outputs change on the same edge.
- Line period is 1344 cycles; frame period is 1344*806 = 1,083,264 cycles.
- Simultaneous wrap at (1343,805) produces (0,0), frame_start_out=1, and vblank_out and hblank_out both falling on that edge.

## Test plan
- Reset/release: hold rst_n=0 for 3 cycles, then check (0,0), syncs=1, blanks=0, frame_start=0. The first cycle after release must show hcount=1, vcount=0.
- Horizontal line: over one line, hblank rises at hcount=1024 and falls at 0; hsync=0 for exactly 136 cycles starting at hcount=1048. Line length is 1344 cycles.
- Vertical frame: vblank rises at (0,768) and vsync=0 for lines 771..776. At the first (0,0) after (1343,805): frame_start=1 for one cycle and vblank=0.
- Frame periodicity: over 3 frames, frame_start pulses exactly 1,083,264 cycles apart. vcount never exceeds 805 and hcount never exceeds 1343.
- Mid-frame reset: assert rst_n=0 for one cycle at (500,400) and check the reset values on the next cycle. Then check (1,0) one cycle after release, and a normal frame_start after a full frame.
- Polarity parameters: with H_SYNC_POL=V_SYNC_POL=1, syncs idle at 0 and are 1 in the same windows; the reset values of the syncs are 0.
